// File: rtl/siso_shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : siso_shift_pkg
// Description : Shared width default and shift-direction encodings.
// Revision    : 1.0
// ============================================================================
package siso_shift_pkg;

    localparam int WIDTH_DEFAULT = 16;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage : siso_shift_pkg
`default_nettype wire

// File: rtl/siso_fifo_shift_register_if.sv
`default_nettype none
// ============================================================================
// Module      : siso_fifo_shift_register_if
// Description : Control, serial and parallel signals of the shift register.
// Revision    : 1.0
// ============================================================================
interface siso_fifo_shift_register_if
    import siso_shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);

    logic             Load;
    logic             Left;
    logic             Din;
    logic [WIDTH-1:0] A;
    logic             Dout;
    logic [WIDTH-1:0] register;

    modport master (
        output Load, Left, Din, A,
        input  Dout, register
    );

    modport slave (
        input  Load, Left, Din, A,
        output Dout, register
    );

endinterface : siso_fifo_shift_register_if
`default_nettype wire

// File: rtl/siso_fifo_shift_register.sv
`default_nettype none
// ============================================================================
// Module      : siso_fifo_shift_register
// Description : Bidirectional serial-in/serial-out shift register with load.
// Revision    : 1.0
// ============================================================================
module siso_fifo_shift_register
    import siso_shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  wire                               Clk,
    input  wire                               Rst,
    siso_fifo_shift_register_if.slave         bus
);

    logic [WIDTH-1:0] r_register;
    logic             r_dout;

    // Load wins; otherwise every edge shifts, Dout takes the bit leaving the register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_register <= '0;
            r_dout     <= 1'b0;
        end else if (bus.Load) begin
            r_register <= bus.A;
        end else if (bus.Left == DIR_LEFT) begin
            r_register <= {r_register[WIDTH-2:0], bus.Din};
            r_dout     <= r_register[WIDTH-1];
        end else begin
            r_register <= {bus.Din, r_register[WIDTH-1:1]};
            r_dout     <= r_register[0];
        end
    end

    assign bus.register = r_register;
    assign bus.Dout     = r_dout;

endmodule : siso_fifo_shift_register
`default_nettype wire

// File: tb/tb_siso_fifo_shift_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_siso_fifo_shift_register
// Description : Directed self-checking bench for siso_fifo_shift_register.
// Revision    : 1.0
// ============================================================================
module tb_siso_fifo_shift_register;
    import siso_shift_pkg::*;

    localparam int WIDTH = 16;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    siso_fifo_shift_register_if #(.WIDTH(WIDTH)) bus ();

    siso_fifo_shift_register #(.WIDTH(WIDTH)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step(input logic load, input logic left, input logic din,
                        input logic [WIDTH-1:0] a);
        @(negedge clk);
        bus.Load = load;
        bus.Left = left;
        bus.Din  = din;
        bus.A    = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        passed   = 0;
        total    = 0;
        rst      = 1'b1;
        bus.Load = 1'b0;
        bus.Left = DIR_RIGHT;
        bus.Din  = 1'b0;
        bus.A    = '0;
        #12;
        check("reset_reg", 32'(bus.register), 32'h0000);
        check("reset_dout", 32'(bus.Dout), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Load then right shift with Din=1
        step(1'b1, DIR_RIGHT, 1'b0, 16'hA5A5);
        check("load_a5a5", 32'(bus.register), 32'hA5A5);
        check("load_dout_hold", 32'(bus.Dout), 32'h0);
        step(1'b0, DIR_RIGHT, 1'b1, 16'h0000);
        check("rshift1_reg", 32'(bus.register), 32'hD2D2);
        check("rshift1_dout", 32'(bus.Dout), 32'h1);
        step(1'b0, DIR_RIGHT, 1'b1, 16'h0000);
        check("rshift2_reg", 32'(bus.register), 32'hE969);
        check("rshift2_dout", 32'(bus.Dout), 32'h0);

        // Immediate direction change to left, Din=0
        step(1'b0, DIR_LEFT, 1'b0, 16'h0000);
        check("lshift1_reg", 32'(bus.register), 32'hD2D2);
        check("lshift1_dout", 32'(bus.Dout), 32'h1);
        step(1'b0, DIR_LEFT, 1'b0, 16'h0000);
        check("lshift2_reg", 32'(bus.register), 32'hA5A4);
        check("lshift2_dout", 32'(bus.Dout), 32'h1);

        // Load overrides shift; Dout holds
        step(1'b1, DIR_LEFT, 1'b1, 16'hABCD);
        check("reload_reg", 32'(bus.register), 32'hABCD);
        check("reload_dout_hold", 32'(bus.Dout), 32'h1);
        step(1'b0, DIR_LEFT, 1'b0, 16'h0000);
        check("lshift3_reg", 32'(bus.register), 32'h579A);
        check("lshift3_dout", 32'(bus.Dout), 32'h1);
        step(1'b0, DIR_LEFT, 1'b0, 16'h0000);
        check("lshift4_reg", 32'(bus.register), 32'hAF34);
        check("lshift4_dout", 32'(bus.Dout), 32'h0);

        // Back-to-back loads
        step(1'b1, DIR_RIGHT, 1'b0, 16'h1111);
        check("bb_load1", 32'(bus.register), 32'h1111);
        step(1'b1, DIR_RIGHT, 1'b1, 16'h2222);
        check("bb_load2", 32'(bus.register), 32'h2222);
        check("bb_dout_hold", 32'(bus.Dout), 32'h0);

        // Serial propagation: a single 1 reaches Dout on the 17th shift edge
        step(1'b1, DIR_RIGHT, 1'b0, 16'h0000);
        check("prop_load0", 32'(bus.register), 32'h0000);
        step(1'b0, DIR_RIGHT, 1'b1, 16'h0000);
        check("prop_edge1_reg", 32'(bus.register), 32'h8000);
        check("prop_edge1_dout", 32'(bus.Dout), 32'h0);
        for (int i = 2; i <= 17; i++) begin
            step(1'b0, DIR_RIGHT, 1'b0, 16'h0000);
            check($sformatf("prop_edge%0d_dout", i), 32'(bus.Dout), (i == 17) ? 32'h1 : 32'h0);
        end
        check("prop_final_reg", 32'(bus.register), 32'h0000);

        // Asynchronous reset between edges while shifting nonzero data
        step(1'b1, DIR_RIGHT, 1'b0, 16'hFFFF);
        step(1'b0, DIR_LEFT, 1'b1, 16'h0000);
        check("pre_rst_reg", 32'(bus.register), 32'hFFFF);
        check("pre_rst_dout", 32'(bus.Dout), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_reg", 32'(bus.register), 32'h0000);
        check("async_rst_dout", 32'(bus.Dout), 32'h0);
        @(posedge clk);
        #1;
        check("rst_held_reg", 32'(bus.register), 32'h0000);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, DIR_LEFT, 1'b1, 16'h1234);
        check("post_rst_load", 32'(bus.register), 32'h1234);
        check("post_rst_dout", 32'(bus.Dout), 32'h0);
        step(1'b0, DIR_LEFT, 1'b1, 16'h0000);
        check("post_rst_lshift", 32'(bus.register), 32'h2469);
        check("post_rst_lshift_dout", 32'(bus.Dout), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_siso_fifo_shift_register
`default_nettype wire

// File: doc/siso_fifo_shift_register.md
SISO_FIFO_SHIFT_REGISTER -- requirements
Module: siso_fifo_shift_register

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 Parameter: WIDTH, default 16, register and parallel-load width in bits; WIDTH SHALL be at least 2.
REQ-003 Port: Clk  input  1  rising-edge clock for all state.
REQ-004 Port: Rst  input  1  asynchronous active-high reset.
REQ-005 Port: Load  input  1  parallel-load strobe; when high, A is captured this edge.
REQ-006 Port: Left  input  1  shift direction: 1 = left (toward MSB), 0 = right (toward LSB).
REQ-007 Port: Din  input  1  serial data in.
REQ-008 Port: A  input  WIDTH  parallel load value.
REQ-009 Port: Dout  output  1  serial data out, registered.
REQ-010 Port: register  output  WIDTH  current register contents, registered.

Function
REQ-011 All state SHALL update only on the rising edge of Clk while Rst is low.
REQ-012 Priority each edge: Load first, else shift; there is no hold state, so a shift occurs every non-load cycle.
REQ-013 Load=1: register <= A; Dout holds its previous value; Left and Din are ignored.
REQ-014 Load=0, Left=0 (right shift): register <= {Din, register[WIDTH-1:1]}; Dout <= old register[0].
REQ-015 Load=0, Left=1 (left shift): register <= {register[WIDTH-2:0], Din}; Dout <= old register[WIDTH-1].
REQ-016 Latency: a Din bit reaches Dout after exactly WIDTH+1 consecutive same-direction shift edges; the register output reflects each edge with zero added latency.
REQ-017 A change of direction between consecutive edges SHALL take effect immediately, with no flush or bubble.
REQ-018 Load asserted on consecutive edges SHALL reload A each edge.
REQ-019 X or Z on inputs is not handled specially.

Reset
REQ-020 While Rst is high: register = 0 and Dout = 0, asynchronously and independent of Clk.
REQ-021 Reset asserted mid-shift or mid-load SHALL discard the operation in progress.
REQ-022 After Rst deasserts, the first rising edge SHALL perform a normal load or shift.

Structure
REQ-023 Shared package siso_shift_pkg SHALL hold the default WIDTH constant (16) and the named direction constants DIR_RIGHT=0 and DIR_LEFT=1.
REQ-024 No sub-module is required; the block is a single module with one always_ff process for register and Dout.

Verification
REQ-025 Reset: assert Rst with register holding nonzero data -> register=0x0000 and Dout=0 immediately, before any clock edge.
REQ-026 Load then right-shift: Load A=0xA5A5, then Left=0, Din=1 for two edges -> register 0xA5A5, 0xD2D2 (Dout=1), 0xE969 (Dout=0).
REQ-027 Left shift: continuing from 0xE969, Left=1, Din=0 for two edges -> register 0xD2D2 (Dout=1), then 0xA5A4 (Dout=1).
REQ-028 Reload over shift: Load=1, A=0xABCD, Left=1 -> register=0xABCD and Dout unchanged; then Left=1, Din=0 for two edges -> 0x579A (Dout=1), then 0xAF34 (Dout=0).
REQ-029 Serial propagation: load 0x0000, then Left=0 with Din=1 for one edge and Din=0 for 16 edges -> Dout=1 exactly on the 17th shift edge.
REQ-030 Reset mid-operation: assert Rst asynchronously between edges during shifting -> outputs clear at once; after deassertion, Load A=0x1234 -> register=0x1234.
